// File: rtl/uart_tx_ctrl.sv
// ----------------------------------------------------------------------------
// uart_tx_ctrl
//
// Frame sequencer for a UART transmitter. It accepts one parallel payload at
// a time and steps a downstream TX mux through start bit, payload bits
// (LSB first), an optional parity bit, and the stop bit. The mux itself,
// which registers tx_out, lives outside this block.
//
// Handshake (data_valid / data_ack):
//   A request is taken on any rising edge where data_valid = 1 and the
//   controller is in IDLE or STOP (and rst = 1). data_ack is a registered
//   one-cycle pulse in the cycle after that edge, i.e. during START. While a
//   frame is in START, DATA or PARITY, data_valid is ignored and the
//   requester must keep it (and p_data) stable until it sees data_ack.
//   Holding data_valid through STOP yields back-to-back frames.
//
// Parameters:
//   DATA_WIDTH  payload bits per frame, 5..8
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-low reset
//   p_data      parallel payload, captured on acceptance
//   data_valid  send request
//   par_en      1 = append parity bit, captured on acceptance
//   par_typ     0 = even, 1 = odd parity, captured on acceptance
//   data_ack    one-cycle acceptance pulse
//   busy        high while a frame is in progress (START..STOP)
//   mux_sel     TX mux select: 00 start, 01 stop/idle, 10 data, 11 parity
//   ser_data    current payload bit (shift register bit 0)
//   par_bit     parity of the latched payload
//   state_dbg   registered FSM state (IDLE=0 START=1 DATA=2 PARITY=3 STOP=4)
// ----------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  data_ack,
    output logic                  busy,
    output logic [1:0]            mux_sel,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic [2:0]            state_dbg
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] MUX_START  = 2'b00;
    localparam logic [1:0] MUX_STOP   = 2'b01;
    localparam logic [1:0] MUX_DATA   = 2'b10;
    localparam logic [1:0] MUX_PARITY = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  accept;
    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  par_en_q;
    logic                  par_typ_q;
    // XOR-reduction of the payload taken at acceptance; the shift register
    // is consumed during DATA, so parity cannot be recomputed from it later.
    logic                  par_raw_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state and acceptance
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (data_valid) begin
                    accept    = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = DATA;
            end
            DATA: begin
                if (bit_cnt == LAST_BIT) begin
                    state_nxt = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                state_nxt = STOP;
            end
            STOP: begin
                // Taking a new request here chains frames with no idle gap.
                if (data_valid) begin
                    accept    = 1'b1;
                    state_nxt = START;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: payload shift register, bit counter, latched options
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_raw_q <= 1'b0;
            data_ack  <= 1'b0;
        end else begin
            data_ack <= accept;
            if (accept) begin
                shreg     <= p_data;
                par_en_q  <= par_en;
                par_typ_q <= par_typ;
                par_raw_q <= ^p_data;
                bit_cnt   <= '0;
            end else begin
                case (state)
                    START: begin
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        shreg <= {1'b0, shreg[DATA_WIDTH-1:1]};
                        // Hold on the last bit so the counter never wraps
                        // inside DATA when DATA_WIDTH is a power of two.
                        if (bit_cnt != LAST_BIT) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // mux_sel depends on the registered state only. The downstream mux adds
    // one register stage; that delay is deliberately not compensated here.
    always_comb begin
        mux_sel = MUX_STOP;
        case (state)
            IDLE:    mux_sel = MUX_STOP;
            START:   mux_sel = MUX_START;
            DATA:    mux_sel = MUX_DATA;
            PARITY:  mux_sel = MUX_PARITY;
            STOP:    mux_sel = MUX_STOP;
            default: mux_sel = MUX_STOP;
        endcase
    end

    assign busy      = (state != IDLE);
    assign ser_data  = shreg[0];
    assign par_bit   = par_raw_q ^ par_typ_q;
    assign state_dbg = state;

endmodule
